shiftreg_receiver: RTL

Serial-to-parallel receiver for the select-framed shift-register link. It samples the serial bit stream under the `SELDYN`/`SELSTAT` frame selects and reassembles the 16-bit dynamic word and the 88-bit static word, MSB first. Each completed word is presented on a parallel output with a one-cycle valid strobe. Aborted or illegal frames are flagged.

---
 rtl/shiftreg_receiver.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/shiftreg_receiver.sv
// shiftreg_receiver: serial-to-parallel receiver for the select-framed
// shift-register link. Reassembles a dynamic and a static word (MSB first)
// under the SELDYN/SELSTAT frame selects, strobes a valid pulse per completed
// word and flags aborted or illegal frames on FRAME_ERR.
module shiftreg_receiver #(
  parameter int SIZESRDYN  = 16,
  parameter int SIZESRSTAT = 88,
  parameter int CNTW       = 7,
  parameter int LAG        = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SELDYN,
  input  logic                  SELSTAT,
  input  logic                  SDATA,
  output logic [SIZESRDYN-1:0]  DYNWORD,
  output logic [SIZESRSTAT-1:0] STATWORD,
  output logic                  DYN_VALID,
  output logic                  STAT_VALID,
  output logic                  FRAME_ERR,
  output logic                  BUSY
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RX_DYN  = 2'd1;
  localparam logic [1:0] ST_RX_STAT = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  // Counter value at which the final bit of each word type arrives
  localparam logic [CNTW-1:0] DYN_LAST  = CNTW'(SIZESRDYN - 1);
  localparam logic [CNTW-1:0] STAT_LAST = CNTW'(SIZESRSTAT - 1);

  // Frame selects as seen by the FSM (optionally delayed to line up with data)
  logic sel_dyn;
  logic sel_stat;

  generate
    if (LAG > 0) begin : g_lag
      logic sel_dyn_reg;
      logic sel_stat_reg;

      // One-flop select delay so the selects align with the sampled data bit
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          sel_dyn_reg  <= 1'b0;
          sel_stat_reg <= 1'b0;
        end else begin
          sel_dyn_reg  <= SELDYN;
          sel_stat_reg <= SELSTAT;
        end
      end

      assign sel_dyn  = sel_dyn_reg;
      assign sel_stat = sel_stat_reg;
    end else begin : g_nolag
      assign sel_dyn  = SELDYN;
      assign sel_stat = SELSTAT;
    end
  endgenerate

  logic is_dyn, is_stat, is_none, is_both;
  assign is_dyn  = sel_dyn & ~sel_stat;
  assign is_stat = sel_stat & ~sel_dyn;
  assign is_none = ~sel_dyn & ~sel_stat;
  assign is_both = sel_dyn & sel_stat;

  logic [1:0]            state_reg, state_next;
  logic [CNTW-1:0]       cnt_reg, cnt_next;
  logic                  type_stat_reg, type_stat_next;
  // Shift registers hold all but the final bit; the final bit is taken from SDATA directly
  logic [SIZESRDYN-2:0]  dyn_sh_reg, dyn_sh_next;
  logic [SIZESRSTAT-2:0] stat_sh_reg, stat_sh_next;
  logic [SIZESRDYN-1:0]  dyn_word_reg, dyn_word_next;
  logic [SIZESRSTAT-1:0] stat_word_reg, stat_word_next;
  logic                  dyn_valid_reg, dyn_valid_next;
  logic                  stat_valid_reg, stat_valid_next;
  logic                  frame_err_reg, frame_err_next;
  logic                  busy_reg, busy_next;

  // Shift register contents with the current serial bit appended at the LSB
  logic [SIZESRDYN-1:0]  dyn_cat;
  logic [SIZESRSTAT-1:0] stat_cat;
  assign dyn_cat  = {dyn_sh_reg, SDATA};
  assign stat_cat = {stat_sh_reg, SDATA};

  logic do_start;

  // Next-state logic: frame tracking, bit assembly, word completion and error detection
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    type_stat_next  = type_stat_reg;
    dyn_sh_next     = dyn_sh_reg;
    stat_sh_next    = stat_sh_reg;
    dyn_word_next   = dyn_word_reg;
    stat_word_next  = stat_word_reg;
    dyn_valid_next  = 1'b0;
    stat_valid_next = 1'b0;
    frame_err_next  = 1'b0;
    do_start        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        do_start = 1'b1;
      end
      ST_RX_DYN: begin
        if (is_dyn) begin
          if (cnt_reg == DYN_LAST) begin
            dyn_word_next  = dyn_cat;
            dyn_valid_next = 1'b1;
            type_stat_next = 1'b0;
            state_next     = ST_HOLD;
          end else begin
            dyn_sh_next = dyn_cat[SIZESRDYN-2:0];
            cnt_next    = cnt_reg + CNTW'(1);
          end
        end else begin
          frame_err_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end
      ST_RX_STAT: begin
        if (is_stat) begin
          if (cnt_reg == STAT_LAST) begin
            stat_word_next  = stat_cat;
            stat_valid_next = 1'b1;
            type_stat_next  = 1'b1;
            state_next      = ST_HOLD;
          end else begin
            stat_sh_next = stat_cat[SIZESRSTAT-2:0];
            cnt_next     = cnt_reg + CNTW'(1);
          end
        end else begin
          frame_err_next = 1'b1;
          state_next     = ST_IDLE;
        end
      end
      default: begin
        // HOLD: ignore overlength bits; a switch to the other select starts a new frame at once
        if (is_both) begin
          frame_err_next = 1'b1;
          state_next     = ST_IDLE;
        end else if (is_none) begin
          state_next = ST_IDLE;
        end else if ((is_dyn && type_stat_reg) || (is_stat && !type_stat_reg)) begin
          do_start = 1'b1;
        end
      end
    endcase

    if (do_start) begin
      if (is_dyn) begin
        dyn_sh_next = dyn_cat[SIZESRDYN-2:0];
        cnt_next    = CNTW'(1);
        state_next  = ST_RX_DYN;
      end else if (is_stat) begin
        stat_sh_next = stat_cat[SIZESRSTAT-2:0];
        cnt_next     = CNTW'(1);
        state_next   = ST_RX_STAT;
      end else if (is_both) begin
        frame_err_next = 1'b1;
        state_next     = ST_IDLE;
      end else begin
        state_next = ST_IDLE;
      end
    end

    busy_next = (state_next == ST_RX_DYN) || (state_next == ST_RX_STAT);
  end

  // State and output registers; reset discards any partial frame silently
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      type_stat_reg  <= 1'b0;
      dyn_sh_reg     <= '0;
      stat_sh_reg    <= '0;
      dyn_word_reg   <= '0;
      stat_word_reg  <= '0;
      dyn_valid_reg  <= 1'b0;
      stat_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      type_stat_reg  <= type_stat_next;
      dyn_sh_reg     <= dyn_sh_next;
      stat_sh_reg    <= stat_sh_next;
      dyn_word_reg   <= dyn_word_next;
      stat_word_reg  <= stat_word_next;
      dyn_valid_reg  <= dyn_valid_next;
      stat_valid_reg <= stat_valid_next;
      frame_err_reg  <= frame_err_next;
      busy_reg       <= busy_next;
    end
  end

  assign DYNWORD    = dyn_word_reg;
  assign STATWORD   = stat_word_reg;
  assign DYN_VALID  = dyn_valid_reg;
  assign STAT_VALID = stat_valid_reg;
  assign FRAME_ERR  = frame_err_reg;
  assign BUSY       = busy_reg;

endmodule
